// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned NUM_WR         = 2;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_SWEEP,
        CLR_DONE
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: sweeps registers 1..NUM_REGS-1 to zero, one per cycle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] PtrFirst = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PtrLast  = '1;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State and sweep pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            ptr_q   <= PtrFirst;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        clr_we     = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clear_req) begin
                    state_d = CLR_SWEEP;
                    ptr_d   = PtrFirst;
                end
            end
            CLR_SWEEP: begin
                clear_busy = 1'b1;
                clr_we     = 1'b1;
                if (ptr_q == PtrLast) begin
                    state_d = CLR_DONE;
                    // Park at 1 so the pointer never wraps onto register 0.
                    ptr_d   = PtrFirst;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            CLR_DONE: begin
                clear_done = 1'b1;
                state_d    = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
                ptr_d   = PtrFirst;
            end
        endcase
    end

    assign clr_addr = ptr_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two synchronous writes,
// register 0 hardwired to zero, sequential clear engine.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          reg_write_en,
    input  logic [NUM_WR*ADDR_W-1:0]   write_dest,
    input  logic [NUM_WR*DATA_W-1:0]   write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic                       clear_done
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [DATA_W-1:0] wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_valid;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wr_addr[k]  = write_dest[k*ADDR_W +: ADDR_W];
        assign wr_data[k]  = write_data[k*DATA_W +: DATA_W];
        assign wr_valid[k] = reg_write_en[k] && (wr_addr[k] != '0);
    end

    // Array next state: the sweep owns the array while busy, otherwise user
    // writes apply in port order so port 1 wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_valid[k]) begin
                    regs_d[wr_addr[k]] = wr_data[k];
                end
            end
        end
    end

    // Storage array with asynchronous clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;

        assign rd_addr = read_reg[i*ADDR_W +: ADDR_W];

        // Read mux: stored value, optionally overridden by a same-cycle write.
        always_comb begin
            rd_val = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (!clear_busy) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_valid[k] && (wr_addr[k] == rd_addr)) begin
                        rd_val = wr_data[k];
                    end
                end
            end
`endif
            if (rd_addr == '0) begin
                rd_val = '0;
            end
        end

        assign read_data[i*DATA_W +: DATA_W] = rd_val;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp with a cycle-indexed reference model.
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NREGS = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        reg_write_en;
    logic [2*AW-1:0]   write_dest;
    logic [2*DW-1:0]   write_data;
    logic [NR*AW-1:0]  read_reg;
    logic [NR*DW-1:0]  read_data;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: array contents plus the edge at which the last clear
    // was accepted. Cycle c is the interval following model edge c.
    logic [DW-1:0] mdl [NREGS];
    int            cyc;
    int            req_edge;
    bit            req_valid;
    int            busy_cnt;
    int            done_cnt;

    register_file_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reg_write_en (reg_write_en),
        .write_dest   (write_dest),
        .write_data   (write_data),
        .read_reg     (read_reg),
        .read_data    (read_data),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sweep occupies cycles req_edge .. req_edge+30, done pulse in the next one.
    function automatic bit mdl_busy(input int c);
        return req_valid && (c >= req_edge) && (c < req_edge + NREGS - 1);
    endfunction

    function automatic bit mdl_done(input int c);
        return req_valid && (c == req_edge + NREGS - 1);
    endfunction

    function automatic logic [DW-1:0] exp_read(input int i);
        logic [AW-1:0] a;
        a = read_reg[i*AW +: AW];
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!mdl_busy(cyc)) begin
            if (reg_write_en[1] && write_dest[AW +: AW] == a) return write_data[DW +: DW];
            if (reg_write_en[0] && write_dest[0 +: AW] == a) return write_data[0 +: DW];
        end
`endif
        return mdl[a];
    endfunction

    task automatic mdl_reset();
        for (int r = 0; r < NREGS; r++) mdl[r] = '0;
        req_valid = 1'b0;
        req_edge  = 0;
        cyc       = 0;
    endtask

    // Apply the clock edge that ends cycle cyc.
    task automatic mdl_edge();
        int c;
        c = cyc;
        if (mdl_busy(c)) begin
            mdl[c + 1 - req_edge] = '0;
        end else begin
            if (reg_write_en[0] && write_dest[0 +: AW] != 0)
                mdl[write_dest[0 +: AW]] = write_data[0 +: DW];
            if (reg_write_en[1] && write_dest[AW +: AW] != 0)
                mdl[write_dest[AW +: AW]] = write_data[DW +: DW];
        end
        if (!mdl_busy(c) && !mdl_done(c) && clear_req) begin
            req_edge  = c + 1;
            req_valid = 1'b1;
        end
        cyc++;
    endtask

    task automatic set_wr(input logic [1:0] en, input int d0, input logic [DW-1:0] v0,
                          input int d1, input logic [DW-1:0] v1);
        reg_write_en          = en;
        write_dest[0 +: AW]   = AW'(d0);
        write_dest[AW +: AW]  = AW'(d1);
        write_data[0 +: DW]   = v0;
        write_data[DW +: DW]  = v1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        read_reg[0 +: AW]  = AW'(a0);
        read_reg[AW +: AW] = AW'(a1);
    endtask

    // Check all outputs at the falling edge, then advance one rising edge.
    task automatic run_cycle();
        @(negedge clk);
        for (int i = 0; i < NR; i++)
            check_eq($sformatf("rd%0d_cyc%0d", i, cyc), read_data[i*DW +: DW], exp_read(i));
        check_eq($sformatf("busy_cyc%0d", cyc), {31'd0, clear_busy}, {31'd0, mdl_busy(cyc)});
        check_eq($sformatf("done_cyc%0d", cyc), {31'd0, clear_done}, {31'd0, mdl_done(cyc)});
        if (clear_busy) busy_cnt++;
        if (clear_done) done_cnt++;
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic fill_index();
        for (int r = 1; r < NREGS; r++) begin
            set_wr((r % 2 == 1) ? 2'b01 : 2'b10, r, DW'(r), r, DW'(r));
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            run_cycle();
        end
        set_wr(2'b00, 0, '0, 0, '0);
    endtask

    initial begin
        reset     = 1'b0;
        clear_req = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        set_wr(2'b00, 0, '0, 0, '0);
        set_rd(0, 0);
        mdl_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        set_rd(3, 17);
        #1;
        check_eq("rst_rd0", read_data[0 +: DW], '0);
        check_eq("rst_rd1", read_data[DW +: DW], '0);
        check_eq("rst_busy", {31'd0, clear_busy}, '0);
        check_eq("rst_done", {31'd0, clear_done}, '0);
        reset = 1'b1;

        // Preload, then assert reset mid-cycle: reads drop to zero at once.
        for (int r = 1; r < NREGS; r++) begin
            set_wr((r % 2 == 1) ? 2'b01 : 2'b10, r, DW'(r * 3 + 1), r, DW'(r * 3 + 1));
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            run_cycle();
        end
        set_wr(2'b00, 0, '0, 0, '0);
        set_rd(7, 20);
        run_cycle();
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_rd0", read_data[0 +: DW], '0);
        check_eq("async_rst_rd1", read_data[DW +: DW], '0);
        check_eq("async_rst_busy", {31'd0, clear_busy}, '0);
        mdl_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Dual write, then read back.
        set_wr(2'b11, 5, 32'd25, 8, 32'd58);
        set_rd(5, 8);
        run_cycle();
        set_wr(2'b00, 0, '0, 0, '0);
        #1;
        check_eq("wr_p0_reg5", read_data[0 +: DW], 32'd25);
        check_eq("wr_p1_reg8", read_data[DW +: DW], 32'd58);
        run_cycle();

        // Register 0 ignores writes.
        set_wr(2'b01, 0, 32'd7, 0, '0);
        set_rd(0, 5);
        run_cycle();
        set_wr(2'b00, 0, '0, 0, '0);
        #1;
        check_eq("reg0_zero", read_data[0 +: DW], '0);
        run_cycle();

        // Collision: port 1 wins.
        set_wr(2'b11, 3, 32'h11, 3, 32'h22);
        set_rd(3, 9);
        run_cycle();
        set_wr(2'b00, 0, '0, 0, '0);
        #1;
        check_eq("collide_reg3", read_data[0 +: DW], 32'h22);
        run_cycle();

        // Bypass: same-cycle write visible only with the option built in.
        set_wr(2'b01, 9, 32'h1234, 0, '0);
        run_cycle();
        set_wr(2'b01, 9, 32'hABCD, 0, '0);
        set_rd(9, 9);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("bypass_reg9", read_data[0 +: DW], 32'hABCD);
`else
        check_eq("bypass_reg9", read_data[0 +: DW], 32'h1234);
`endif
        run_cycle();

        // Full sweep with a dropped mid-sweep write and an ignored re-request.
        fill_index();
        busy_cnt  = 0;
        done_cnt  = 0;
        clear_req = 1'b1;
        run_cycle();
        for (int j = 0; j < 40; j++) begin
            if (j == 5) begin
                set_wr(2'b01, 4, 32'h77, 0, '0);
                clear_req = 1'b1;
            end else begin
                set_wr(2'b00, 0, '0, 0, '0);
                clear_req = 1'b0;
            end
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            run_cycle();
        end
        check_eq("sweep_busy_len", busy_cnt, 32'd31);
        check_eq("sweep_done_pulses", done_cnt, 32'd1);
        for (int r = 1; r < NREGS; r += 2) begin
            set_rd(r, (r + 1) % NREGS);
            #1;
            check_eq($sformatf("swept_reg%0d", r), read_data[0 +: DW], '0);
            run_cycle();
        end

        // Reset in the middle of a sweep.
        fill_index();
        clear_req = 1'b1;
        run_cycle();
        clear_req = 1'b0;
        repeat (10) run_cycle();
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, clear_busy}, '0);
        check_eq("abort_done", {31'd0, clear_done}, '0);
        mdl_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        done_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            run_cycle();
        end
        check_eq("abort_no_done", done_cnt, '0);
        for (int r = 1; r < NREGS; r += 2) begin
            set_rd(r, (r + 1) % NREGS);
            run_cycle();
        end
        clear_req = 1'b1;
        run_cycle();
        clear_req = 1'b0;
        #1;
        check_eq("reclear_busy", {31'd0, clear_busy}, 32'd1);

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 3000; n++) begin
            reg_write_en = 2'($urandom_range(0, 3));
            write_dest[0 +: AW]  = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3)
                                                                    : $urandom_range(0, 31));
            write_dest[AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3)
                                                                    : $urandom_range(0, 31));
            write_data[0 +: DW]  = $urandom;
            write_data[DW +: DW] = $urandom;
            set_rd(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            clear_req = ($urandom_range(0, 63) == 0);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
